// File: rtl/ghash_pkg.sv
// Shared types, constants and the single-bit GF(2^128) shift/reduce step for the GHASH multiplier.
// Uses the NIST SP 800-38D reflected bit order, so vector bit 127 holds coefficient x^0.
package ghash_pkg;

  localparam int DATA__WIDTH = 128;
  localparam int SPLIT_WIDTH = 32;
  localparam int NUM_STAGES  = DATA__WIDTH / SPLIT_WIDTH;

  typedef logic [DATA__WIDTH-1:0] gf128_t;

  localparam gf128_t GF128_R   = 128'hE1000000000000000000000000000000;
  localparam gf128_t GF128_ONE = 128'h80000000000000000000000000000000;

  // Multiply V by x: a right shift in reflected order, folding x^128 back in via R.
  function automatic gf128_t gf128_shift_reduce(input gf128_t v);
    gf128_shift_reduce = v[0] ? ((v >> 1) ^ GF128_R) : (v >> 1);
  endfunction

endpackage

// File: rtl/ghash_mul_stage.sv
// One registered pipeline slice: consumes SPLIT_WIDTH bits of H, MSB first,
// advancing the running product Z and the shifted multiplicand V.
module ghash_mul_stage
  import ghash_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  gf128_t                 z_i,
  input  gf128_t                 v_i,
  input  logic [SPLIT_WIDTH-1:0] h_i,
  output gf128_t                 z_o,
  output gf128_t                 v_o
);

  gf128_t z_d, z_q;
  gf128_t v_d, v_q;

  always_comb begin
    z_d = z_i;
    v_d = v_i;
    for (int i = 0; i < SPLIT_WIDTH; i++) begin
      if (h_i[SPLIT_WIDTH-1-i]) begin
        z_d = z_d ^ v_d;
      end
      v_d = gf128_shift_reduce(v_d);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      z_q <= '0;
      v_q <= '0;
    end else begin
      z_q <= z_d;
      v_q <= v_d;
    end
  end

  assign z_o = z_q;
  assign v_o = v_q;

endmodule

// File: rtl/ghash_gf128_mul.sv
// Four-stage pipelined GF(2^128) multiplier for GHASH: mul_o = a_i * H, one product per cycle.
// Define GHASH_HH_DEBUG_EN to add a parallel pipeline producing H*H on AA_o (otherwise AA_o = 0).
module ghash_gf128_mul
  import ghash_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SPLIT_WIDTH-1:0] ha_i,
  input  logic [SPLIT_WIDTH-1:0] hb_i,
  input  logic [SPLIT_WIDTH-1:0] hc_i,
  input  logic [SPLIT_WIDTH-1:0] hd_i,
  input  gf128_t                 a_i,
  output gf128_t                 mul_o,
  output gf128_t                 AA_o
);

  // Not-yet-consumed H words travel alongside their operand so H may change every cycle.
  logic [3*SPLIT_WIDTH-1:0] hrem1_d, hrem1_q;
  logic [2*SPLIT_WIDTH-1:0] hrem2_d, hrem2_q;
  logic [SPLIT_WIDTH-1:0]   hrem3_d, hrem3_q;
  logic [SPLIT_WIDTH-1:0]   hword [0:NUM_STAGES-1];

  always_comb begin
    hrem1_d  = {hb_i, hc_i, hd_i};
    hrem2_d  = hrem1_q[2*SPLIT_WIDTH-1:0];
    hrem3_d  = hrem2_q[SPLIT_WIDTH-1:0];
    hword[0] = ha_i;
    hword[1] = hrem1_q[3*SPLIT_WIDTH-1:2*SPLIT_WIDTH];
    hword[2] = hrem2_q[2*SPLIT_WIDTH-1:SPLIT_WIDTH];
    hword[3] = hrem3_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hrem1_q <= '0;
      hrem2_q <= '0;
      hrem3_q <= '0;
    end else begin
      hrem1_q <= hrem1_d;
      hrem2_q <= hrem2_d;
      hrem3_q <= hrem3_d;
    end
  end

  gf128_t mul_z [0:NUM_STAGES];
  gf128_t mul_v [0:NUM_STAGES];

  assign mul_z[0] = '0;
  assign mul_v[0] = a_i;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_mul
    ghash_mul_stage u_stage (
      .clk (clk),
      .rst (rst),
      .z_i (mul_z[s]),
      .v_i (mul_v[s]),
      .h_i (hword[s]),
      .z_o (mul_z[s+1]),
      .v_o (mul_v[s+1])
    );
  end

  assign mul_o = mul_z[NUM_STAGES];

`ifdef GHASH_HH_DEBUG_EN
  gf128_t hh_z [0:NUM_STAGES];
  gf128_t hh_v [0:NUM_STAGES];

  assign hh_z[0] = '0;
  assign hh_v[0] = {ha_i, hb_i, hc_i, hd_i};

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_hh
    ghash_mul_stage u_stage (
      .clk (clk),
      .rst (rst),
      .z_i (hh_z[s]),
      .v_i (hh_v[s]),
      .h_i (hword[s]),
      .z_o (hh_z[s+1]),
      .v_o (hh_v[s+1])
    );
  end

  assign AA_o = hh_z[NUM_STAGES];
`else
  assign AA_o = '0;
`endif

endmodule

// File: tb/tb_ghash_gf128_mul.sv
// Self-checking bench for ghash_gf128_mul: known-answer table, randomized stream against a
// polynomial-arithmetic reference model, and reset corner cases.
module tb_ghash_gf128_mul;
  import ghash_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [SPLIT_WIDTH-1:0] ha_i, hb_i, hc_i, hd_i;
  gf128_t                 a_i;
  gf128_t                 mul_o;
  gf128_t                 AA_o;

  int numChecks = 0;
  int numFails  = 0;

  localparam gf128_t H_ID   = 128'h42831ec2217774244b7221b784d0d49c;
  localparam gf128_t H_TC2  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam gf128_t C_TC2  = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam gf128_t X1_TC2 = 128'h5e2ec746917062882c85b0685353deb7;
  localparam gf128_t LEN2   = 128'h00000000000000000000000000000080;
  localparam gf128_t GH_TC2 = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
  localparam int     NSTREAM = 40;

  typedef struct {
    string  name;
    gf128_t h;
    gf128_t a;
    gf128_t expMul;
  } vec_t;

  vec_t   vecs [8];
  gf128_t streamH   [NSTREAM];
  gf128_t streamA   [NSTREAM];
  gf128_t streamMul [NSTREAM];
  gf128_t streamAA  [NSTREAM];

  ghash_gf128_mul dut (
    .clk   (clk),
    .rst   (rst),
    .ha_i  (ha_i),
    .hb_i  (hb_i),
    .hc_i  (hc_i),
    .hd_i  (hd_i),
    .a_i   (a_i),
    .mul_o (mul_o),
    .AA_o  (AA_o)
  );

  always #5 clk = ~clk;

  // Convert between GCM reflected order and ordinary polynomial order (bit i = x^i).
  function automatic gf128_t reflect(input gf128_t x);
    gf128_t r;
    for (int i = 0; i < 128; i++) r[i] = x[127-i];
    return r;
  endfunction

  // Reference: carry-less polynomial product followed by long division by x^128+x^7+x^2+x+1.
  function automatic gf128_t refMul(input gf128_t x, input gf128_t h);
    logic [255:0] prod;
    logic [255:0] poly;
    logic [255:0] px;
    gf128_t       ph;
    px   = {128'b0, reflect(x)};
    ph   = reflect(h);
    prod = '0;
    poly = {127'b0, 1'b1, 128'h87};
    for (int i = 0; i < 128; i++) begin
      if (ph[i]) prod = prod ^ (px << i);
    end
    for (int i = 254; i >= 128; i--) begin
      if (prod[i]) prod = prod ^ (poly << (i - 128));
    end
    return reflect(prod[127:0]);
  endfunction

  function automatic gf128_t expectedAA(input gf128_t h);
`ifdef GHASH_HH_DEBUG_EN
    return refMul(h, h);
`else
    return h & 128'h0;
`endif
  endfunction

  function automatic gf128_t rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic applyStimulus(input gf128_t h, input gf128_t a);
    {ha_i, hb_i, hc_i, hd_i} = h;
    a_i = a;
  endtask

  task automatic checkOutput(input string name, input gf128_t actual, input gf128_t expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  initial begin
    vecs[0] = '{"identity",       H_ID,      GF128_ONE,        H_ID};
    vecs[1] = '{"zero operand",   H_ID,      128'h0,           128'h0};
    vecs[2] = '{"tc2 step1",      H_TC2,     C_TC2,            X1_TC2};
    vecs[3] = '{"tc2 length blk", H_TC2,     X1_TC2 ^ LEN2,    GH_TC2};
    vecs[4] = '{"H one",          GF128_ONE, C_TC2,            C_TC2};
    vecs[5] = '{"a equals H",     H_ID,      H_ID,             refMul(H_ID, H_ID)};
    vecs[6] = '{"commutative",    C_TC2,     H_TC2,            X1_TC2};
    vecs[7] = '{"random",         rand128(), rand128(),        128'h0};
    vecs[7].expMul = refMul(vecs[7].a, vecs[7].h);

    // Reset held with random inputs, then three cycles of zeros after release.
    rst = 1'b0;
    applyStimulus(rand128(), rand128());
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checkOutput("reset mul_o", mul_o, 128'h0);
      checkOutput("reset AA_o",  AA_o,  128'h0);
      applyStimulus(rand128(), rand128());
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkOutput("post-release mul_o", mul_o, 128'h0);
      checkOutput("post-release AA_o",  AA_o,  128'h0);
    end

    // Known-answer table: hold each vector and read the result after four edges.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].h, vecs[i].a);
      repeat (4) @(posedge clk);
      #1;
      checkOutput({vecs[i].name, " mul_o"}, mul_o, vecs[i].expMul);
      checkOutput({vecs[i].name, " AA_o"},  AA_o,  expectedAA(vecs[i].h));
    end

    // Back-to-back stream: two NIST vectors with different H first, then random operands.
    for (int i = 0; i < NSTREAM; i++) begin
      streamH[i] = rand128();
      streamA[i] = rand128();
    end
    streamH[0] = H_TC2; streamA[0] = C_TC2;
    streamH[1] = H_ID;  streamA[1] = X1_TC2 ^ LEN2;
    streamH[2] = H_TC2; streamA[2] = X1_TC2 ^ LEN2;
    for (int i = 0; i < NSTREAM; i++) begin
      streamMul[i] = refMul(streamA[i], streamH[i]);
      streamAA[i]  = expectedAA(streamH[i]);
    end
    streamMul[0] = X1_TC2;
    streamMul[2] = GH_TC2;
    for (int cyc = 0; cyc < NSTREAM + 3; cyc++) begin
      if (cyc < NSTREAM) applyStimulus(streamH[cyc], streamA[cyc]);
      else               applyStimulus(rand128(), rand128());
      @(posedge clk); #1;
      if (cyc >= 3) begin
        checkOutput($sformatf("stream[%0d] mul_o", cyc - 3), mul_o, streamMul[cyc-3]);
        checkOutput($sformatf("stream[%0d] AA_o",  cyc - 3), AA_o,  streamAA[cyc-3]);
      end
    end

    // Asynchronous reset in the middle of a cycle must clear both outputs at once.
    applyStimulus(H_ID, GF128_ONE);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("pre-reset mul_o", mul_o, H_ID);
    checkOutput("pre-reset AA_o",  AA_o,  expectedAA(H_ID));
    #3;
    rst = 1'b0;
    #1;
    checkOutput("async reset mul_o", mul_o, 128'h0);
    checkOutput("async reset AA_o",  AA_o,  128'h0);
    @(posedge clk); #1;
    checkOutput("held reset mul_o", mul_o, 128'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("flushed mul_o", mul_o, 128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
